// File: rtl/mem_arbiter.sv
// Purpose : shares one multi-cycle data memory between the CPU MEM stage and a
//           DMA/loader port, and steers CPU addresses >= IO_BASE to a zero-wait IO port.
// Latency : each memory access takes WAIT_STATES+1 BUSY cycles after an IDLE grant cycle.
//           IO accesses are combinational.
// Backpressure: the CPU is held with cpu_stall. The DMA holds dma_req until the
//           one-cycle dma_ack pulse.
//
// Ports   : clock/reset (synchronous, active-high); cpu_* pipeline MEM-stage request,
//           response and stall; dma_* loader request with an ack pulse; mem_* single-port
//           memory; io_* IO block.
// Build   : define ARB_FIXED_PRIO_EN to make the CPU always win simultaneous requests.
//           Leave it undefined for round-robin arbitration.

module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] IO_BASE     = 16'hFFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        io_en,
    output logic        io_we,
    output logic [3:0]  io_addr,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam logic       OWN_CPU = 1'b0;
    localparam logic       OWN_DMA = 1'b1;
    localparam logic [3:0] WS_CNT  = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;

    logic io_hit;
    logic mreq_c;
    logic done;
    logic cpu_done;
    logic dma_done;
    logic grant_dma;

    assign io_hit = cpu_req & (cpu_addr >= IO_BASE);
    assign mreq_c = cpu_req & ~io_hit;

    // Completion is masked while reset is asserted. A reset that lands on the
    // last access cycle therefore aborts the access without an ack.
    assign done     = (state_q == ST_BUSY) & (cnt_q == 4'd0) & ~reset;
    assign cpu_done = done & (owner_q == OWN_CPU);
    assign dma_done = done & (owner_q == OWN_DMA);

    // grant_dma is only consulted when at least one requester is active.
    // If the CPU is not requesting memory, the DMA must be the one requesting.
`ifdef ARB_FIXED_PRIO_EN
    assign grant_dma = ~mreq_c;
`else
    assign grant_dma = mreq_c ? (dma_req & (last_q == OWN_CPU)) : 1'b1;
`endif

    // State register and all datapath flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DMA;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            cpu_rdata_q <= 16'h0000;
            dma_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mreq_c | dma_req) state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == 4'd0)    state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // Grant latching, wait-state countdown and completion bookkeeping.
    always_comb begin
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mreq_c | dma_req) begin
                    owner_d     = grant_dma ? OWN_DMA : OWN_CPU;
                    cnt_d       = WS_CNT;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_dma ? dma_we    : cpu_we;
                    mem_addr_d  = grant_dma ? dma_addr  : cpu_addr;
                    mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    last_d   = owner_q;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                    else                    dma_rdata_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Outputs. Completion data is forwarded straight from the memory so the
    // requester sees it in the completion cycle rather than one cycle later.
    always_comb begin
        cpu_stall = mreq_c & ~cpu_done;
        if (io_hit & ~cpu_we) cpu_rdata = io_rdata;
        else if (cpu_done)    cpu_rdata = mem_rdata;
        else                  cpu_rdata = cpu_rdata_q;
        dma_ack   = dma_done;
        dma_rdata = dma_done ? mem_rdata : dma_rdata_q;
        io_en     = io_hit;
        io_we     = cpu_we & io_hit;
        io_addr   = cpu_addr[3:0];
        io_wdata  = cpu_wdata;
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. A transaction-level model predicts every output
// each cycle, and directed scenarios add hand-computed literal expectations.
// Define ARB_FIXED_PRIO_EN for both DUT and bench to exercise the fixed-priority build.

module tb_mem_arbiter;
    localparam int WS = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata, io_wdata, io_rdata;
    logic        cpu_stall, dma_ack, mem_en, mem_we, io_en, io_we;
    logic [3:0]  io_addr;

    logic [15:0] mem_arr [0:255];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit started = 1'b0;

    always #5 clock = ~clock;

    assign mem_rdata = mem_arr[mem_addr[7:0]];
    assign io_rdata  = 16'h5A5A;

    mem_arbiter #(.WAIT_STATES(WS), .IO_BASE(16'hFFF0)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory backing store. Writes land at the clock edge. The array is
    // reinitialised on reset so every scenario starts from known contents.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 16'h0000;
            mem_arr[8'h16] <= 16'h007E;
            mem_arr[8'h20] <= 16'hBEEF;
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // Transaction model: one access in flight, tracked by owner and by elapsed
    // cycles since the grant. It finishes after WS+1 cycles in flight.
    logic        m_busy, m_owner, m_last, m_we;
    int          m_el;
    logic [15:0] m_addr, m_wdata, m_cpu_rd, m_dma_rd;

    always @(posedge clock) begin : model
        logic hit, mreq, fin, win;
        hit  = cpu_req && (cpu_addr >= 16'hFFF0);
        mreq = cpu_req && !hit;
        fin  = m_busy && (m_el == WS + 1);
        if (reset) begin
            m_busy = 0; m_owner = 0; m_last = 1; m_we = 0; m_el = 0;
            m_addr = 0; m_wdata = 0; m_cpu_rd = 0; m_dma_rd = 0;
        end else if (fin) begin
            if (m_owner) m_dma_rd = mem_arr[m_addr[7:0]];
            else         m_cpu_rd = mem_arr[m_addr[7:0]];
            m_last = m_owner;
            m_busy = 0;
        end else if (m_busy) begin
            m_el = m_el + 1;
        end else if (mreq || dma_req) begin
            if (mreq && dma_req) begin
`ifdef ARB_FIXED_PRIO_EN
                win = 1'b0;
`else
                win = !m_last;
`endif
            end else begin
                win = !mreq;
            end
            m_owner = win;
            m_busy  = 1;
            m_el    = 1;
            m_addr  = win ? dma_addr  : cpu_addr;
            m_we    = win ? dma_we    : cpu_we;
            m_wdata = win ? dma_wdata : cpu_wdata;
        end
        started = 1'b1;
    end

    always @(negedge clock) begin : cmp
        logic hit, mreq, fin;
        logic [15:0] e_crd, e_drd;
        if (started) begin
            hit  = cpu_req && (cpu_addr >= 16'hFFF0);
            mreq = cpu_req && !hit;
            fin  = m_busy && (m_el == WS + 1) && !reset;
            if (hit && !cpu_we)   e_crd = io_rdata;
            else if (fin && !m_owner) e_crd = mem_arr[m_addr[7:0]];
            else                  e_crd = m_cpu_rd;
            e_drd = (fin && m_owner) ? mem_arr[m_addr[7:0]] : m_dma_rd;
            chk("cpu_stall", cpu_stall, mreq && !(fin && !m_owner));
            chk("cpu_rdata", cpu_rdata, e_crd);
            chk("dma_ack",   dma_ack,   fin && m_owner);
            chk("dma_rdata", dma_rdata, e_drd);
            chk("mem_en",    mem_en,    m_busy);
            chk("mem_we",    mem_we,    m_busy && m_we);
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("io_en",     io_en,     hit);
            chk("io_we",     io_we,     hit && cpu_we);
            chk("io_addr",   io_addr,   cpu_addr[3:0]);
            chk("io_wdata",  io_wdata,  cpu_wdata);
        end
    end

    task automatic nxt;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int cpu_done[$];
        int ack_at;
        int n_ack;
        reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        nxt; nxt;
        @(negedge clock);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);

        // CPU load 0x0016 returns 0x007E: two stall cycles, then data.
        nxt; reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0016;
        @(negedge clock); chk("ld_stall0", cpu_stall, 1); chk("ld_men0", mem_en, 0);
        nxt; @(negedge clock); chk("ld_stall1", cpu_stall, 1); chk("ld_men1", mem_en, 1);
        nxt; @(negedge clock); chk("ld_stall2", cpu_stall, 0); chk("ld_data", cpu_rdata, 16'h007E);
        chk("ld_men2", mem_en, 1);
        nxt; cpu_req = 0;
        @(negedge clock); chk("ld_men3", mem_en, 0); chk("ld_hold", cpu_rdata, 16'h007E);

        // DMA read 0x0020, with a CPU IO store issued while the DMA is busy.
        nxt; dma_req = 1; dma_we = 0; dma_addr = 16'h0020;
        nxt; cpu_req = 1; cpu_we = 1; cpu_addr = 16'hFFFA; cpu_wdata = 16'h0030;
        @(negedge clock);
        chk("io_en", io_en, 1); chk("io_addr", io_addr, 4'hA);
        chk("io_wdata", io_wdata, 16'h0030); chk("io_stall", cpu_stall, 0);
        nxt; cpu_req = 0; cpu_we = 0;
        @(negedge clock); chk("dma_ack", dma_ack, 1); chk("dma_rd", dma_rdata, 16'hBEEF);
        nxt; dma_req = 0;
        @(negedge clock); chk("dma_ack_low", dma_ack, 0); chk("dma_rd_hold", dma_rdata, 16'hBEEF);

        // DMA write 0x1234 to 0x0008, then a CPU read of the same address.
        nxt; dma_req = 1; dma_we = 1; dma_addr = 16'h0008; dma_wdata = 16'h1234;
        nxt; @(negedge clock); chk("dw_we1", mem_we, 1);
        nxt; @(negedge clock); chk("dw_we2", mem_we, 1); chk("dw_ack", dma_ack, 1);
        nxt; dma_req = 0; dma_we = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0008;
        nxt; @(negedge clock); chk("cr_we", mem_we, 0); chk("cr_en", mem_en, 1);
        nxt; @(negedge clock); chk("cr_stall", cpu_stall, 0); chk("cr_data", cpu_rdata, 16'h1234);
        nxt; cpu_req = 0;

        // Simultaneous requests after reset. The CPU keeps requesting after its first completion.
        reset = 1; nxt; reset = 0;
        cpu_req = 1; cpu_addr = 16'h0016; dma_req = 1; dma_we = 0; dma_addr = 16'h0020;
        ack_at = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (cpu_req && !cpu_stall) cpu_done.push_back(i);
            if (dma_ack) ack_at = i;
            nxt;
            if (cpu_done.size() >= 2) cpu_req = 0;
            if (ack_at >= 0) dma_req = 0;
        end
        chk("tie_cpu_n", cpu_done.size(), 2);
        if (cpu_done.size() >= 2) begin
            chk("tie_cpu_first", cpu_done[0], 2);
`ifdef ARB_FIXED_PRIO_EN
            chk("tie_cpu_second", cpu_done[1], 5);
            chk("tie_ack", ack_at, 8);
`else
            chk("tie_ack_gap", ack_at - cpu_done[0], 3);
            chk("tie_cpu_second", cpu_done[1], 8);
`endif
        end

        // Reset in the first BUSY cycle of a DMA read aborts it. The held request is then re-granted.
        dma_req = 1; dma_we = 0; dma_addr = 16'h0020;
        nxt; reset = 1;
        @(negedge clock); chk("ab_men_busy", mem_en, 1);
        nxt; reset = 0;
        @(negedge clock); chk("ab_men", mem_en, 0); chk("ab_ack", dma_ack, 0);
        chk("ab_drd", dma_rdata, 16'h0000);
        ack_at = -1;
        for (int i = 0; i < 10 && ack_at < 0; i++) begin
            if (dma_ack) begin
                ack_at = i;
                chk("ab_re_data", dma_rdata, 16'hBEEF);
            end
            nxt; @(negedge clock);
        end
        chk("ab_re_ack", ack_at, 2);
        nxt; dma_req = 0;

        // A continuously requesting CPU against the DMA for 20 cycles.
        nxt; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0016;
        dma_req = 1; dma_addr = 16'h0020;
        n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (dma_ack) n_ack++;
            nxt;
            if (n_ack > 0) dma_req = 0;
        end
`ifdef ARB_FIXED_PRIO_EN
        chk("starve_acks", n_ack, 0);
`else
        chk("rr_acks", n_ack, 1);
`endif
        cpu_req = 0; dma_req = 0;
        nxt; nxt;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, multi-cycle data memory between two requesters: the CPU pipeline MEM stage and a DMA/program-loader port.
- Decodes CPU addresses at or above IO_BASE (switches at 0xFFF0, display at 0xFFFA) onto a zero-wait IO port that bypasses arbitration.
- Stalls the pipeline while a CPU memory access is pending.
- Sits between the pipeline MEM stage, the data memory and the IO block.

Parameters:
- WAIT_STATES, 1, extra memory cycles per access beyond the first (0..15).
- IO_BASE, 16'hFFF0, CPU addresses >= IO_BASE go to the IO port.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU MEM-stage load/store request; held until cpu_stall=0.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  16  byte address.
- cpu_wdata  in  16  store data.
- cpu_rdata  out  16  load data; valid in the cycle cpu_stall falls.
- cpu_stall  out  1  freeze pipeline.
- dma_req  in  1  DMA request; held until dma_ack.
- dma_we  in  1  1=write.
- dma_addr  in  16  address; never IO-decoded.
- dma_wdata  in  16  write data.
- dma_rdata  out  16  read data; valid with dma_ack, held afterwards.
- dma_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; valid in the last access cycle.
- io_en  out  1  IO access strobe.
- io_we  out  1  IO write.
- io_addr  out  4  cpu_addr[3:0].
- io_wdata  out  16  IO write data.
- io_rdata  in  16  IO read data.

Behaviour:
- Clocking and reset: single clock, reset synchronous and active-high. Reset to IDLE from any state; this aborts an in-flight access with no ack.
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, dma_ack=0, cpu_rdata=0, dma_rdata=0, cnt=0, owner=CPU, last=DMA.
- io_hit = cpu_req & (cpu_addr >= IO_BASE).
- IO path is combinational:
  - io_en=io_hit, io_we=cpu_we&io_hit, io_wdata=cpu_wdata.
  - cpu_rdata=io_rdata when io_hit & ~cpu_we.
  - Never stalls; legal while the DMA owns memory.
- mreq_c = cpu_req & ~io_hit.
- FSM IDLE:
  - If mreq_c or dma_req: grant per priority.
  - Latch the winner's addr/we/wdata into mem_* and set mem_en=1, cnt=WAIT_STATES, owner=winner.
  - Go to BUSY.
- FSM BUSY:
  - mem_* held constant.
  - While cnt!=0, cnt decrements each cycle.
  - At cnt==0 (completion cycle):
    - Owner CPU: cpu_stall=0 and cpu_rdata=mem_rdata combinationally; the registered copy updates at the edge.
    - Owner DMA: dma_ack=1 and dma_rdata=mem_rdata.
    - last=owner, mem_en/mem_we cleared, go to IDLE.
- Priority on a simultaneous mreq_c and dma_req: round-robin; grant the requester other than last. A lone request always wins.
- cpu_stall = mreq_c & ~(BUSY & owner==CPU & cnt==0), combinational.
- Latency: a CPU memory access stalls for WAIT_STATES+1 cycles and completes in cycle WAIT_STATES+2 counting the request cycle. A DMA request seen in the same cycle as a CPU completion is granted in the following IDLE cycle. No back-to-back grants skip IDLE.
- A CPU request that arrives while the DMA is BUSY stalls until the DMA completes, then competes in IDLE.
- A request dropped by a requester before completion is a protocol error and is not checked. The access still completes and the result is discarded.
- Memory writes: mem_we is held through BUSY, so repeat writes of the same data are harmless.
- cpu_rdata holds its last memory value between accesses, except when IO-overridden.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: the CPU always wins simultaneous requests and last is ignored. The DMA can starve; accepted for debug loaders.
- Undefined: round-robin as above.
- Ports and latency are identical in both builds.

Test Plan:
- Reset, WAIT_STATES=1, CPU load addr 0x0016 with mem returning 0x007E -> cpu_stall=1 for 2 cycles; stall low in the third cycle with cpu_rdata=0x007E; mem_en high 2 cycles.
- CPU store 0x0030 to 0xFFFA while the DMA is BUSY on 0x0020 -> io_en=1, io_addr=0xA, io_wdata=0x0030 same cycle, cpu_stall=0; DMA completes unaffected.
- CPU and DMA request together after reset -> CPU granted first (last=DMA); dma_ack arrives 3 cycles after CPU completion. Repeat the tie -> DMA granted first.
- Same tie with ARB_FIXED_PRIO_EN defined and CPU requesting continuously -> dma_ack never asserts over 20 cycles.
- DMA write 0x1234 to 0x0008, then CPU load 0x0008 -> mem_we held for the DMA access only; cpu_rdata=0x1234.
- Reset asserted in the first BUSY cycle of a DMA read -> next cycle IDLE, mem_en=0, no dma_ack. The held dma_req is re-granted and acked normally.
